// File: rtl/mult_controller.sv
// ---------------------------------------------------------------------------
// mult_controller
//
// Moore FSM that sequences a shift-and-add multiplier datapath. Each of the
// WIDTH iterations visits TEST and SHIFT, with an ADD in between whenever the
// multiplier LSB is one. All control outputs are decoded from the registered
// state only, so there is no combinational path from inputs to outputs.
//
// Parameters
//   WIDTH    multiplier operand width = iteration count (2..16)
//
// Ports
//   clk      clock, all state changes on the rising edge
//   clr      asynchronous active-low reset (forces IDLE, counter 0)
//   start    begin one multiplication; only sampled in IDLE
//   b_lsb    LSB of the datapath multiplier register
//   b_zero   datapath multiplier register is all zero
//   load     load operand registers A, B
//   clr_acc  clear the product accumulator
//   add_en   accumulator += shifted multiplicand
//   shift    multiplicand << 1, multiplier >> 1
//   busy     high in every legal state except IDLE
//   done     one-cycle pulse, product valid in the accumulator
//   state    current state code (debug / LED display)
//
// Build option
//   MULT_CTRL_EARLY_EXIT_EN  when defined, TEST jumps straight to DONE as
//                            soon as b_zero is high. When undefined, b_zero
//                            is present but ignored.
// ---------------------------------------------------------------------------
module mult_controller #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       b_lsb,
    input  logic       b_zero,
    output logic       load,
    output logic       clr_acc,
    output logic       add_en,
    output logic       shift,
    output logic       busy,
    output logic       done,
    output logic [2:0] state
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_LOAD  = 3'b001;
    localparam logic [2:0] S_TEST  = 3'b010;
    localparam logic [2:0] S_ADD   = 3'b011;
    localparam logic [2:0] S_SHIFT = 3'b100;
    localparam logic [2:0] S_DONE  = 3'b101;

    logic [2:0]       state_r;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic             early_exit;

`ifdef MULT_CTRL_EARLY_EXIT_EN
    // Remaining multiplier bits are all zero: nothing left to add.
    assign early_exit = b_zero;
`else
    logic unused_b_zero;
    assign early_exit    = 1'b0;
    assign unused_b_zero = b_zero;
`endif

    // State register and iteration counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt;
            if (state_r == S_LOAD) begin
                cnt_r <= '0;
            end else if (state_r == S_SHIFT && cnt_r != LAST_ITER) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_IDLE;
        case (state_r)
            S_IDLE:  state_nxt = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_nxt = S_TEST;
            S_TEST: begin
                if (early_exit) begin
                    state_nxt = S_DONE;
                end else if (b_lsb) begin
                    state_nxt = S_ADD;
                end else begin
                    state_nxt = S_SHIFT;
                end
            end
            S_ADD:   state_nxt = S_SHIFT;
            S_SHIFT: state_nxt = (cnt_r == LAST_ITER) ? S_DONE : S_TEST;
            // DONE always passes through IDLE, so a held start costs one
            // IDLE cycle between operations.
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode (registered state only); illegal codes drive nothing
    always_comb begin
        load    = 1'b0;
        clr_acc = 1'b0;
        add_en  = 1'b0;
        shift   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_r)
            S_LOAD: begin
                load    = 1'b1;
                clr_acc = 1'b1;
                busy    = 1'b1;
            end
            S_TEST:  busy = 1'b1;
            S_ADD: begin
                add_en = 1'b1;
                busy   = 1'b1;
            end
            S_SHIFT: begin
                shift = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_r;

endmodule
